// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the hardware interrupt front end:
// address width, default vector layout and the request FSM encoding.
package cpu_pkg;

  localparam int ADDR_W = 20;

  localparam logic [ADDR_W-1:0] DEFAULT_VEC_BASE  = 20'h00100;
  localparam int                DEFAULT_VEC_SHIFT = 2;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

  // Vector address for an interrupt ID; wraps modulo 2^ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] irq_vector(
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] id,
    input int                shift
  );
    return base + (id << shift);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: multi-flop synchroniser followed by a history flop,
// producing a single-cycle pulse on each synchronised rising edge.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/hard_irq_ctrl.sv
// Hardware interrupt front end: edge capture, pending/mask registers, fixed
// priority selection and a single outstanding request held until iret.
module hard_irq_ctrl
  import cpu_pkg::*;
#(
  parameter int                NUM_IRQ     = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] VEC_BASE    = DEFAULT_VEC_BASE,
  parameter int                VEC_SHIFT   = DEFAULT_VEC_SHIFT,
  localparam int               ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] hardInterrupt,
  input  logic               maskWe,
  input  logic [NUM_IRQ-1:0] maskIn,
  output logic [NUM_IRQ-1:0] maskOut,
  output logic [NUM_IRQ-1:0] pending,
  output logic               irqReq,
  output logic [ID_W-1:0]    irqId,
  output logic [ADDR_W-1:0]  irqVector,
  input  logic               irqAck,
  input  logic               iRetDone,
  output logic               inService
);

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ack_clear;
  logic [ID_W-1:0]    winner;
  logic               any_eligible;
  logic               ack_take;
  irq_state_e         state_q;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .din (hardInterrupt[i]),
      .rise(rise[i])
    );
  end

  assign eligible = pending & ~maskOut;
  assign ack_take = (state_q == IRQ_REQ) && irqAck;

  // NOTE: defaults are assigned before the loop so every path drives the
  // outputs; a missing default would infer a latch.
  always_comb begin
    winner       = '0;
    any_eligible = 1'b0;
    // Scan downwards so the lowest set index is the last, winning assignment.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner       = ID_W'(i);
        any_eligible = 1'b1;
      end
    end
  end

  always_comb begin
    ack_clear = '0;
    if (ack_take) ack_clear[irqId] = 1'b1;
  end

  // A new edge on the acknowledged line is OR-ed in after the clear, so it
  // survives as a fresh pending event.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      maskOut <= '0;
    end else begin
      pending <= (pending & ~ack_clear) | rise;
      if (maskWe) maskOut <= maskIn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IRQ_IDLE;
      irqReq    <= 1'b0;
      irqId     <= '0;
      irqVector <= VEC_BASE;
      inService <= 1'b0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (any_eligible) begin
            irqId     <= winner;
            irqVector <= irq_vector(VEC_BASE, ADDR_W'(winner), VEC_SHIFT);
            irqReq    <= 1'b1;
            state_q   <= IRQ_REQ;
          end
        end
        // ID and vector stay frozen here; the request is never withdrawn.
        IRQ_REQ: begin
          if (irqAck) begin
            irqReq    <= 1'b0;
            inService <= 1'b1;
            state_q   <= IRQ_SERVICE;
          end
        end
        IRQ_SERVICE: begin
          if (iRetDone) begin
            inService <= 1'b0;
            state_q   <= IRQ_IDLE;
          end
        end
        default: begin
          irqReq    <= 1'b0;
          inService <= 1'b0;
          state_q   <= IRQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hard_irq_ctrl.sv
// Self-checking bench for hard_irq_ctrl: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_hard_irq_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  hw;
  logic        mwe;
  logic [3:0]  min;
  logic [3:0]  mask_out;
  logic [3:0]  pend_out;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic [19:0] irq_vec;
  logic        ack;
  logic        iret;
  logic        in_svc;

  always #5 clk = ~clk;

  hard_irq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .hardInterrupt(hw),
    .maskWe       (mwe),
    .maskIn       (min),
    .maskOut      (mask_out),
    .pending      (pend_out),
    .irqReq       (irq_req),
    .irqId        (irq_id),
    .irqVector    (irq_vec),
    .irqAck       (ack),
    .iRetDone     (iret),
    .inService    (in_svc)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 requesting, 2 in service.
  int          m_mode;
  logic [3:0]  m_pend, m_mask;
  logic [1:0]  m_id;
  logic [19:0] m_vec;
  logic        m_req, m_insv;
  logic [3:0]  m_hist [0:S];

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // A 0->1 step in the sampled pin sequence becomes pending S+1 edges later.
  task automatic model_step();
    logic [3:0] ev;
    logic [3:0] elig;
    int         w;
    if (rst) begin
      m_mode = 0; m_pend = '0; m_mask = '0; m_id = '0;
      m_vec = 20'h00100; m_req = 1'b0; m_insv = 1'b0;
      for (int j = 0; j <= S; j++) m_hist[j] = '0;
      return;
    end
    ev = m_hist[S-1] & ~m_hist[S];
    for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = hw;
    elig = m_pend & ~m_mask;
    if (m_mode == 0) begin
      w = lowest(elig);
      if (w >= 0) begin
        m_id   = 2'(w);
        m_vec  = 20'(32'h00100 + w * 4);
        m_req  = 1'b1;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (ack) begin
        m_pend[m_id] = 1'b0;
        m_req  = 1'b0;
        m_insv = 1'b1;
        m_mode = 2;
      end
    end else if (iret) begin
      m_insv = 1'b0;
      m_mode = 0;
    end
    m_pend = m_pend | ev;
    if (mwe) m_mask = min;
  endtask

  bit rand_on = 0;
  bit auto_on = 0;
  int svc_cnt = 0;
  int ack_count = 0;
  int req_rises = 0;
  logic prev_req = 1'b0;

  task automatic tick();
    if (rand_on) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) hw[i] = ~hw[i];
      mwe  = ($urandom_range(0, 15) == 0);
      min  = 4'($urandom);
      ack  = irq_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      iret = in_svc  ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      rst  = ($urandom_range(0, 299) == 0);
    end else if (auto_on) begin
      ack = irq_req;
      if (ack) ack_count++;
      svc_cnt = in_svc ? svc_cnt + 1 : 0;
      iret = in_svc && (svc_cnt == 3);
    end
    @(posedge clk);
    model_step();
    #1;
    check("req", irq_req, m_req);
    check("id", irq_id, m_id);
    check("vec", irq_vec, m_vec);
    check("pend", pend_out, m_pend);
    check("mask", mask_out, m_mask);
    check("insvc", in_svc, m_insv);
    if (irq_req && !prev_req) req_rises++;
    prev_req = irq_req;
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!irq_req && n < max) begin
      tick();
      n++;
    end
    if (!irq_req) check("req_timeout", irq_req, 1'b1);
  endtask

  task automatic serve();
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    iret = 1'b1; tick(); iret = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; hw = '0; mwe = 1'b0; min = '0; ack = 1'b0; iret = 1'b0;
    for (int j = 0; j <= S; j++) m_hist[j] = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_req", irq_req, 1'b0);
    check("rst_vec", irq_vec, 20'h00100);
    check("rst_insvc", in_svc, 1'b0);
    repeat (7) tick();

    // Pin 0 rises: request appears four edges later.
    hw = 4'b0001;
    repeat (3) tick();
    check("t1_early", irq_req, 1'b0);
    tick();
    check("t1_req", irq_req, 1'b1);
    check("t1_id", irq_id, 2'd0);
    check("t1_vec", irq_vec, 20'h00100);
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    check("t1_pend", pend_out, 4'b0000);
    check("t1_insvc", in_svc, 1'b1);
    repeat (3) tick();
    iret = 1'b1; tick(); iret = 1'b0;
    check("t1_ret", in_svc, 1'b0);
    tick();
    check("t1_noreq", irq_req, 1'b0);

    // Pins 1 and 2 together: priority then the leftover.
    hw = 4'b0111;
    wait_req(10);
    check("t2_id1", irq_id, 2'd1);
    check("t2_vec1", irq_vec, 20'h00104);
    serve();
    wait_req(10);
    check("t2_id2", irq_id, 2'd2);
    check("t2_vec2", irq_vec, 20'h00108);
    serve();

    // Masked pin 3 stays pending, requests once unmasked.
    mwe = 1'b1; min = 4'b1000; tick(); mwe = 1'b0;
    hw = 4'b1111;
    repeat (5) tick();
    check("t3_pend", pend_out, 4'b1000);
    check("t3_masked", irq_req, 1'b0);
    mwe = 1'b1; min = 4'b0000; tick(); mwe = 1'b0;
    tick();
    check("t3_req", irq_req, 1'b1);
    check("t3_id", irq_id, 2'd3);
    check("t3_vec", irq_vec, 20'h0010C);
    serve();
    hw = 4'b0000;
    repeat (4) tick();

    // Request for ID 2 is frozen while pin 0 arrives; pin 2 re-rises on ack.
    hw = 4'b0100;
    wait_req(10);
    check("t4_id", irq_id, 2'd2);
    hw = 4'b0101; tick();
    hw = 4'b0001; tick(); tick();
    hw = 4'b0101; tick(); tick();
    check("t4_hold", irq_id, 2'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    check("t4_pend", pend_out, 4'b0101);
    tick();
    iret = 1'b1; tick(); iret = 1'b0;
    wait_req(5);
    check("t4_id0", irq_id, 2'd0);
    serve();
    wait_req(5);
    check("t4_id2", irq_id, 2'd2);
    serve();
    hw = 4'b0000;
    repeat (4) tick();

    // Level-held pin produces exactly one request.
    auto_on = 1; req_rises = 0;
    hw = 4'b0010;
    repeat (50) tick();
    check("hold_one", req_rises, 1);
    auto_on = 0;

    // Reset in the middle of service.
    mwe = 1'b1; min = 4'b0100; tick(); mwe = 1'b0;
    hw = 4'b0000; repeat (3) tick();
    hw = 4'b0010;
    wait_req(10);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    check("t5_insvc", in_svc, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_rst_insvc", in_svc, 1'b0);
    check("t5_rst_mask", mask_out, 4'b0000);
    check("t5_rst_pend", pend_out, 4'b0000);
    check("t5_rst_vec", irq_vec, 20'h00100);
    hw = 4'b0000;
    auto_on = 1; repeat (20) tick(); auto_on = 0;
    iret = 1'b1; tick(); iret = 1'b0;
    check("stray_iret_insvc", in_svc, 1'b0);
    check("stray_iret_req", irq_req, 1'b0);
    ack = 1'b1; tick(); ack = 1'b0;
    check("stray_ack_insvc", in_svc, 1'b0);

    // Glitch then a three-cycle pulse on pin 3.
    auto_on = 1; ack_count = 0;
    hw = 4'b1000; tick();
    hw = 4'b0000; tick();
    hw = 4'b1000; repeat (3) tick();
    hw = 4'b0000;
    repeat (30) tick();
    check("glitch_acks", ack_count, 2);
    auto_on = 0;

    // Random traffic.
    rand_on = 1;
    repeat (3000) tick();
    rand_on = 0;
    rst = 1'b0; hw = '0; ack = 1'b0; iret = 1'b0;
    mwe = 1'b1; min = '0; tick(); mwe = 1'b0;
    auto_on = 1; repeat (60) tick(); auto_on = 0;
    check("drain_pend", pend_out, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
